// File: rtl/seq_mult_bw.sv
// seq_mult_bw: iterative signed/unsigned WIDTH x WIDTH multiplier, one partial-product row per clock.
module seq_mult_bw #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] y
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic sm_reg;
   logic [CW-1:0] count;
   logic [2*WIDTH-1:0] acc, a_ext, row, acc_nxt;
   logic accept, last;
   assign accept = start && ready;
   assign last = (state == RUN) && (count == LAST);
   // the sign row of a two's-complement multiplier carries negative weight
   assign a_ext = sm_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
   assign row = b_reg[count] ? (a_ext << count) : '0;
   assign acc_nxt = (sm_reg && count == LAST) ? acc - row : acc + row;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = (state == RUN) ? (count == LAST ? DONE : RUN) : (start ? RUN : IDLE);
   always_comb begin
      ready = state != RUN;
      busy = state == RUN;
      done = state == DONE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         sm_reg <= 1'b0;
         acc <= '0;
         count <= '0;
         y <= '0;
      end else if (accept) begin
         a_reg <= a;
         b_reg <= b;
         sm_reg <= signed_mode;
         acc <= '0;
         count <= '0;
      end else if (state == RUN) begin
         acc <= acc_nxt;
         count <= count + 1'b1;
         if (last) y <= acc_nxt;
      end
endmodule

// File: tb/tb_seq_mult_bw.sv
// tb_seq_mult_bw: table vectors plus handshake/reset sequences, checked through an expected-result queue.
module tb_seq_mult_bw;
   logic clk = 0, rst_n = 0;
   logic start8 = 0, sm8 = 0, start3 = 0, sm3 = 0;
   logic [7:0] a8 = 0, b8 = 0;
   logic [2:0] a3 = 0, b3 = 0;
   logic ready8, busy8, done8, ready3, busy3, done3;
   logic [15:0] y8;
   logic [5:0] y3;
   int total = 0, bad = 0, n_done8 = 0;
   logic [63:0] q8[$], q3[$];
   typedef struct {logic [7:0] a; logic [7:0] b; logic sm; logic [15:0] y;} vec_t;
   vec_t tbl[8];

   seq_mult_bw #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8), .y(y8));
   seq_mult_bw #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .start(start3), .signed_mode(sm3),
      .a(a3), .b(b3), .ready(ready3), .busy(busy3), .done(done3), .y(y3));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] z, input logic sm, input int w);
      longint xv = longint'(x), zv = longint'(z);
      if (sm && x[w-1]) xv -= longint'(1) << w;
      if (sm && z[w-1]) zv -= longint'(1) << w;
      return 64'(xv * zv) & ((64'(1) << (2 * w)) - 1);
   endfunction

   always @(posedge clk) begin
      if (rst_n && start8 && ready8) q8.push_back(model(32'(a8), 32'(b8), sm8, 8));
      if (rst_n && start3 && ready3) q3.push_back(model(32'(a3), 32'(b3), sm3, 3));
   end

   always @(negedge clk) begin
      if (rst_n && done8) begin
         n_done8++;
         if (q8.size() == 0) chk("unexpected_done8", 1, 0);
         else chk("sb_y8", 64'(y8), q8.pop_front());
      end
      if (rst_n && done3) begin
         if (q3.size() == 0) chk("unexpected_done3", 1, 0);
         else chk("sb_y3", 64'(y3), q3.pop_front());
      end
   end

   task automatic mul8(input logic [7:0] aa, input logic [7:0] bb, input logic sm, input bit poke,
                       output int lat, output int bsy);
      @(negedge clk);
      a8 = aa; b8 = bb; sm8 = sm; start8 = 1;
      @(posedge clk); #1;
      start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      lat = 0;
      bsy = busy8 ? 1 : 0;
      while (!done8 && lat < 40) begin
         if (poke) start8 = (lat == 3);
         @(posedge clk); #1;
         lat++;
         if (busy8) bsy++;
      end
      if (lat >= 40) chk("timeout8", 1, 0);
   endtask

   task automatic mul3(input logic [2:0] aa, input logic [2:0] bb, input logic sm);
      int n = 0;
      @(negedge clk);
      a3 = aa; b3 = bb; sm3 = sm; start3 = 1;
      @(posedge clk); #1;
      start3 = 0; a3 = 3'($urandom); b3 = 3'($urandom);
      while (!done3 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("timeout3", 1, 0);
   endtask

   initial begin
      int lat, bsy, n, d0;
      tbl[0] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
      tbl[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      tbl[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      tbl[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      tbl[4] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
      tbl[5] = '{8'h00, 8'h80, 1'b1, 16'h0000};
      tbl[6] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
      tbl[7] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
      #2;
      chk("rst_ready", 64'(ready8), 1);
      chk("rst_busy", 64'(busy8), 0);
      chk("rst_done", 64'(done8), 0);
      chk("rst_y", 64'(y8), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      foreach (tbl[i]) begin
         mul8(tbl[i].a, tbl[i].b, tbl[i].sm, 0, lat, bsy);
         chk($sformatf("tbl_y[%0d]", i), 64'(y8), 64'(tbl[i].y));
         chk($sformatf("tbl_lat[%0d]", i), 64'(lat), 8);
      end
      mul8(8'hFD, 8'h05, 1, 1, lat, bsy);
      chk("poke_y", 64'(y8), 16'hFFF1);
      chk("poke_busy_cycles", 64'(bsy), 8);
      @(posedge clk); #1;
      chk("y_held", 64'(y8), 16'hFFF1);
      chk("idle_ready", 64'(ready8), 1);
      // start held high: a new operation is taken in every DONE cycle
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; sm8 = 0; start8 = 1;
      n = 0;
      while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin @(posedge clk); #1; n++; end while (!done8 && n < 40);
         chk("b2b_period", 64'(n), 9);
      end
      start8 = 0;
      repeat (3) @(posedge clk);
      // asynchronous reset in the middle of RUN
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h77; sm8 = 0; start8 = 1;
      @(posedge clk); #1;
      start8 = 0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 0;
      q8.delete();
      d0 = n_done8;
      #1;
      chk("mid_rst_y", 64'(y8), 0);
      chk("mid_rst_busy", 64'(busy8), 0);
      chk("mid_rst_ready", 64'(ready8), 1);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (12) @(posedge clk);
      chk("no_done_after_rst", 64'(n_done8), 64'(d0));
      mul8(8'hFD, 8'h05, 1, 0, lat, bsy);
      chk("post_rst_y", 64'(y8), 16'hFFF1);
      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 8; x++)
            for (int z = 0; z < 8; z++)
               mul3(3'(x), 3'(z), 1'(s));
      mul3(3'b100, 3'b011, 1);
      chk("w3_corner", 64'(y3), 6'b110100);
      repeat (2) @(posedge clk);
      chk("q8_drained", 64'(q8.size()), 0);
      chk("q3_drained", 64'(q3.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
